// File: rtl/sync_bit_pkg.sv
// ---------------------------------------------------------------------------
// sync_bit_pkg
// Shared definitions for the synchronized-bit filter slice:
//   - sbState_t : filter FSM state (2-bit encoding, values are fixed)
//   - PEND_W    : width of the pending-sample counter
//   - satMax()  : largest value representable in a counter of a given width
// ---------------------------------------------------------------------------
package sync_bit_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } sbState_t;

    localparam int PEND_W = 8;

    // Saturation ceiling for a width-bit counter (all ones).
    function automatic int unsigned satMax(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_bit_sat_cnt.sv
// ---------------------------------------------------------------------------
// sync_bit_sat_cnt
// Saturating up-counter with synchronous clear.
//   sCLK : clock, posedge
//   sRST : asynchronous active-low reset (count -> 0)
//   en   : qualifies increments only
//   inc  : increment request
//   clr  : synchronous clear; wins over inc and ignores en
//   cnt  : current count, holds at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sync_bit_sat_cnt
    import sync_bit_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          sCLK,
    input  logic          sRST,
    input  logic          en,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] MAX_CNT = CW'(satMax(CW));

    always_ff @(posedge sCLK or negedge sRST) begin
        if (!sRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && inc && (cnt != MAX_CNT)) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sync_bit_filter.sv
// ---------------------------------------------------------------------------
// sync_bit_filter
// Sits right after a two-register bit synchronizer in the destination domain.
// A level change on dD_IN is accepted only after STABLE_CNT consecutive
// identical samples; shorter excursions are discarded.
//
// Ports:
//   dCLK        : destination clock, posedge
//   dRST        : asynchronous active-low reset
//   dD_IN       : synchronized input bit
//   dEN         : enable; 0 freezes FSM, pending count, level and counters
//   dCNT_CLR    : synchronous clear of the event counter(s), ignores dEN
//   dQ          : filtered level (registered)
//   dRISE/dFALL : single-cycle pulses on accepted 0->1 / 1->0
//   dEVT_CNT    : saturating count of accepted rises
//   dGLITCH_CNT : saturating count of aborted attempts
//                 (only when SYNC_BIT_FILTER_GLITCH_CNT_EN is defined)
//
// Parameters: init (reset level), STABLE_CNT (1..255), CW (counter width).
// ---------------------------------------------------------------------------
module sync_bit_filter
    import sync_bit_pkg::*;
#(
    parameter logic init       = 1'b0,
    parameter int   STABLE_CNT = 4,
    parameter int   CW         = 8
) (
    input  logic          dCLK,
    input  logic          dRST,
    input  logic          dD_IN,
    input  logic          dEN,
    input  logic          dCNT_CLR,
    output logic          dQ,
    output logic          dRISE,
    output logic          dFALL,
    output logic [CW-1:0] dEVT_CNT
`ifdef SYNC_BIT_FILTER_GLITCH_CNT_EN
    ,
    output logic [CW-1:0] dGLITCH_CNT
`endif
);

    localparam sbState_t RESET_STATE = init ? STABLE_HI : STABLE_LO;
    // With a single required sample a change is accepted straight from the
    // stable state, so the pending states are never visited.
    localparam logic SINGLE = (STABLE_CNT == 1);

    sbState_t          state;
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pendInc;
    logic              pendDone;
    logic              acceptRise;
    logic              acceptFall;

    assign pendInc  = pend + PEND_W'(1);
    assign pendDone = (pendInc == PEND_W'(STABLE_CNT));

    // Accept decisions are shared by the FSM and the event counter so the
    // count moves on the same edge that raises dRISE.
    assign acceptRise = dEN && dD_IN &&
                        (((state == STABLE_LO) && SINGLE) ||
                         ((state == PEND_HI) && pendDone));
    assign acceptFall = dEN && !dD_IN &&
                        (((state == STABLE_HI) && SINGLE) ||
                         ((state == PEND_LO) && pendDone));

    always_ff @(posedge dCLK or negedge dRST) begin
        if (!dRST) begin
            state <= RESET_STATE;
            pend  <= '0;
            dQ    <= init;
            dRISE <= 1'b0;
            dFALL <= 1'b0;
        end else begin
            // Pulses last one cycle; also forced low while disabled.
            dRISE <= 1'b0;
            dFALL <= 1'b0;
            if (dEN) begin
                if (acceptRise) begin
                    state <= STABLE_HI;
                    pend  <= '0;
                    dQ    <= 1'b1;
                    dRISE <= 1'b1;
                end else if (acceptFall) begin
                    state <= STABLE_LO;
                    pend  <= '0;
                    dQ    <= 1'b0;
                    dFALL <= 1'b1;
                end else begin
                    case (state)
                        STABLE_LO: begin
                            if (dD_IN) begin
                                state <= PEND_HI;
                                pend  <= PEND_W'(1);
                            end
                        end
                        PEND_HI: begin
                            if (dD_IN) begin
                                pend <= pendInc;
                            end else begin
                                state <= STABLE_LO;
                                pend  <= '0;
                            end
                        end
                        STABLE_HI: begin
                            if (!dD_IN) begin
                                state <= PEND_LO;
                                pend  <= PEND_W'(1);
                            end
                        end
                        PEND_LO: begin
                            if (!dD_IN) begin
                                pend <= pendInc;
                            end else begin
                                state <= STABLE_HI;
                                pend  <= '0;
                            end
                        end
                        default: begin
                            state <= RESET_STATE;
                            pend  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    sync_bit_sat_cnt #(
        .CW (CW)
    ) uEvtCnt (
        .sCLK (dCLK),
        .sRST (dRST),
        .en   (dEN),
        .inc  (acceptRise),
        .clr  (dCNT_CLR),
        .cnt  (dEVT_CNT)
    );

`ifdef SYNC_BIT_FILTER_GLITCH_CNT_EN
    // An attempt is aborted when the input reverts before the pending count
    // reaches STABLE_CNT.
    logic abortAttempt;

    assign abortAttempt = dEN &&
                          (((state == PEND_HI) && !dD_IN) ||
                           ((state == PEND_LO) &&  dD_IN));

    sync_bit_sat_cnt #(
        .CW (CW)
    ) uGlitchCnt (
        .sCLK (dCLK),
        .sRST (dRST),
        .en   (dEN),
        .inc  (abortAttempt),
        .clr  (dCNT_CLR),
        .cnt  (dGLITCH_CNT)
    );
`else
    // Glitch counter not built: aborted attempts are simply dropped.
`endif

endmodule

// File: tb/tb_sync_bit_filter.sv
module tb_sync_bit_filter;

    typedef struct {
        logic       din;
        logic       en;
        logic       clr;
        logic       q;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
        logic [7:0] gl;
        string      nm;
    } vec_t;

    logic dCLK = 1'b0;
    always #5 dCLK = ~dCLK;

    logic dRST;

    // DUT A: init=0, STABLE_CNT=4, CW=8
    logic       dInA, enA, clrA, qA, riseA, fallA;
    logic [7:0] cntA;
    // DUT B: init=1, STABLE_CNT=1, CW=3
    logic       dInB, enB, clrB, qB, riseB, fallB;
    logic [2:0] cntB;
`ifdef SYNC_BIT_FILTER_GLITCH_CNT_EN
    logic [7:0] glA;
    logic [2:0] glB;
`endif

    sync_bit_filter #(.init(1'b0), .STABLE_CNT(4), .CW(8)) dutA (
        .dCLK(dCLK), .dRST(dRST), .dD_IN(dInA), .dEN(enA), .dCNT_CLR(clrA),
        .dQ(qA), .dRISE(riseA), .dFALL(fallA), .dEVT_CNT(cntA)
`ifdef SYNC_BIT_FILTER_GLITCH_CNT_EN
        , .dGLITCH_CNT(glA)
`endif
    );

    sync_bit_filter #(.init(1'b1), .STABLE_CNT(1), .CW(3)) dutB (
        .dCLK(dCLK), .dRST(dRST), .dD_IN(dInB), .dEN(enB), .dCNT_CLR(clrB),
        .dQ(qB), .dRISE(riseB), .dFALL(fallB), .dEVT_CNT(cntB)
`ifdef SYNC_BIT_FILTER_GLITCH_CNT_EN
        , .dGLITCH_CNT(glB)
`endif
    );

    int checks = 0;
    int errors = 0;

    vec_t sbA[$];
    vec_t sbB[$];
    vec_t tblA[$];
    vec_t tblB[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic din, input logic en, input logic clr,
                                input logic q, input logic rise, input logic fall,
                                input int cnt, input int gl, input string nm);
        vec_t v;
        v.din = din; v.en = en; v.clr = clr;
        v.q = q; v.rise = rise; v.fall = fall;
        v.cnt = 8'(cnt); v.gl = 8'(gl); v.nm = nm;
        return v;
    endfunction

    task automatic driveA(input vec_t v);
        @(negedge dCLK);
        dInA = v.din; enA = v.en; clrA = v.clr;
        sbA.push_back(v);
    endtask

    task automatic driveB(input vec_t v);
        @(negedge dCLK);
        dInB = v.din; enB = v.en; clrB = v.clr;
        sbB.push_back(v);
    endtask

    // Scoreboard checkers: outputs sampled 1 time unit after the edge that
    // consumed the vector.
    initial begin : checkA
        vec_t e;
        forever begin
            @(posedge dCLK);
            #1;
            if (sbA.size() > 0) begin
                e = sbA.pop_front();
                $display("A %-10s din=%b en=%b clr=%b q=%b rise=%b fall=%b cnt=%0d",
                         e.nm, e.din, e.en, e.clr, qA, riseA, fallA, cntA);
                chk({"A.", e.nm, ".q"},    {7'b0, qA},    {7'b0, e.q});
                chk({"A.", e.nm, ".rise"}, {7'b0, riseA}, {7'b0, e.rise});
                chk({"A.", e.nm, ".fall"}, {7'b0, fallA}, {7'b0, e.fall});
                chk({"A.", e.nm, ".cnt"},  cntA,          e.cnt);
`ifdef SYNC_BIT_FILTER_GLITCH_CNT_EN
                chk({"A.", e.nm, ".glitch"}, glA, e.gl);
`endif
            end
        end
    end

    initial begin : checkB
        vec_t e;
        forever begin
            @(posedge dCLK);
            #1;
            if (sbB.size() > 0) begin
                e = sbB.pop_front();
                $display("B %-10s din=%b en=%b clr=%b q=%b rise=%b fall=%b cnt=%0d",
                         e.nm, e.din, e.en, e.clr, qB, riseB, fallB, cntB);
                chk({"B.", e.nm, ".q"},    {7'b0, qB},    {7'b0, e.q});
                chk({"B.", e.nm, ".rise"}, {7'b0, riseB}, {7'b0, e.rise});
                chk({"B.", e.nm, ".fall"}, {7'b0, fallB}, {7'b0, e.fall});
                chk({"B.", e.nm, ".cnt"},  {5'b0, cntB},  e.cnt);
`ifdef SYNC_BIT_FILTER_GLITCH_CNT_EN
                chk({"B.", e.nm, ".glitch"}, {5'b0, glB}, e.gl);
`endif
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        // ---------------- vector tables ----------------
        repeat (3) tblA.push_back(mk(0,1,0, 0,0,0, 0,0, "idle"));
        tblA.push_back(mk(1,1,0, 0,0,0, 0,0, "pendHi1"));
        tblA.push_back(mk(1,1,0, 0,0,0, 0,0, "pendHi2"));
        tblA.push_back(mk(1,1,0, 0,0,0, 0,0, "pendHi3"));
        tblA.push_back(mk(1,1,0, 1,1,0, 1,0, "accRise"));
        tblA.push_back(mk(1,1,0, 1,0,0, 1,0, "riseOnce"));
        repeat (3) tblA.push_back(mk(0,1,0, 1,0,0, 1,0, "pendLo"));
        tblA.push_back(mk(0,1,0, 0,0,1, 1,0, "accFall"));
        tblA.push_back(mk(0,1,0, 0,0,0, 1,0, "fallOnce"));
        repeat (3) tblA.push_back(mk(1,1,0, 0,0,0, 1,0, "glitchHi"));
        tblA.push_back(mk(0,1,0, 0,0,0, 1,1, "abortHi"));
        tblA.push_back(mk(0,1,0, 0,0,0, 1,1, "lowHold"));
        repeat (2) tblA.push_back(mk(1,1,0, 0,0,0, 1,1, "enPend"));
        repeat (5) tblA.push_back(mk(1,0,0, 0,0,0, 1,1, "enFrozen"));
        tblA.push_back(mk(1,1,0, 0,0,0, 1,1, "enResume"));
        tblA.push_back(mk(1,1,0, 1,1,0, 2,1, "enAccRise"));
        tblA.push_back(mk(1,1,0, 1,0,0, 2,1, "hiHold"));
        tblA.push_back(mk(1,0,1, 1,0,0, 0,0, "clrNoEn"));
        tblA.push_back(mk(1,1,0, 1,0,0, 0,0, "clrHold"));
        repeat (2) tblA.push_back(mk(0,1,0, 1,0,0, 0,0, "glitchLo"));
        tblA.push_back(mk(1,1,0, 1,0,0, 0,1, "abortLo"));
        tblA.push_back(mk(1,1,0, 1,0,0, 0,1, "hiHold2"));
        repeat (3) tblA.push_back(mk(0,1,0, 1,0,0, 0,1, "pendLo2"));
        tblA.push_back(mk(0,1,0, 0,0,1, 0,1, "accFall2"));
        tblA.push_back(mk(0,1,0, 0,0,0, 0,1, "loHold"));

        // STABLE_CNT=1 toggling: dQ follows dD_IN one cycle later, every
        // change is an accepted edge; rises saturate the 3-bit counter at 7.
        for (int i = 0; i < 18; i++) begin
            bit d;
            int rises;
            d = i[0];
            rises = (i + 1) / 2;
            tblB.push_back(mk(d,1,0, d,d,!d, (rises > 7) ? 7 : rises, 0,
                              $sformatf("tog%0d", i)));
        end
        tblB.push_back(mk(0,1,0, 0,0,1, 7,0, "preClr"));
        tblB.push_back(mk(1,1,1, 1,1,0, 0,0, "clrRise"));
        tblB.push_back(mk(1,1,0, 1,0,0, 0,0, "postClr"));

        // ---------------- reset values ----------------
        dRST = 1'b0;
        dInA = 1'b0; enA = 1'b1; clrA = 1'b0;
        dInB = 1'b1; enB = 1'b1; clrB = 1'b0;
        repeat (3) @(posedge dCLK);
        #1;
        chk("rst.A.q", {7'b0, qA}, 8'd0);
        chk("rst.A.rise", {7'b0, riseA}, 8'd0);
        chk("rst.A.fall", {7'b0, fallA}, 8'd0);
        chk("rst.A.cnt", cntA, 8'd0);
        chk("rst.B.q", {7'b0, qB}, 8'd1);
        chk("rst.B.rise", {7'b0, riseB}, 8'd0);
        chk("rst.B.fall", {7'b0, fallB}, 8'd0);
        chk("rst.B.cnt", {5'b0, cntB}, 8'd0);
        @(negedge dCLK);
        dRST = 1'b1;

        // ---------------- table-driven runs ----------------
        foreach (tblA[i]) driveA(tblA[i]);
        foreach (tblB[i]) driveB(tblB[i]);

        // ---------------- reset in the middle of PEND_HI ----------------
        driveA(mk(1,1,0, 0,0,0, 0,1, "rstPend1"));
        driveA(mk(1,1,0, 0,0,0, 0,1, "rstPend2"));
        @(posedge dCLK);
        #2;
        dRST = 1'b0;
        #1;
        chk("midRst.A.q", {7'b0, qA}, 8'd0);
        chk("midRst.A.rise", {7'b0, riseA}, 8'd0);
        chk("midRst.A.cnt", cntA, 8'd0);
        chk("midRst.B.q", {7'b0, qB}, 8'd1);
        chk("midRst.B.cnt", {5'b0, cntB}, 8'd0);
        @(negedge dCLK);
        dInA = 1'b0;
        @(negedge dCLK);
        dRST = 1'b1;
        repeat (3) driveA(mk(0,1,0, 0,0,0, 0,0, "rstRel"));

        repeat (2) @(posedge dCLK);
        #2;
        chk("sbA.drained", 8'(sbA.size()), 8'd0);
        chk("sbB.drained", 8'(sbB.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
